// File: rtl/logcap_trigger_sequencer_if.sv
// logcap_trigger_sequencer_if: config, arm/abort, sample and status signals of the trigger sequencer
interface logcap_trigger_sequencer_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int STAGE_W      = 4
);
    logic                    cfg_we;
    logic [STAGE_W-1:0]      cfg_stage;
    logic [1:0]              cfg_field;
    logic [SAMPLE_WIDTH-1:0] cfg_data;
    logic [STAGE_W-1:0]      cfg_last_stage;
    logic                    arm;
    logic                    abort;
    logic                    sample_valid;
    logic [SAMPLE_WIDTH-1:0] sample_data;
    logic                    idle;
    logic                    running;
    logic                    triggered;
    logic                    trig_pulse;
    logic [STAGE_W-1:0]      current_stage;
    logic [31:0]             trigger_index;
    logic                    cfg_err;

    modport master (
        output cfg_we, cfg_stage, cfg_field, cfg_data, cfg_last_stage, arm, abort, sample_valid, sample_data,
        input  idle, running, triggered, trig_pulse, current_stage, trigger_index, cfg_err
    );
    modport slave (
        input  cfg_we, cfg_stage, cfg_field, cfg_data, cfg_last_stage, arm, abort, sample_valid, sample_data,
        output idle, running, triggered, trig_pulse, current_stage, trigger_index, cfg_err
    );
endinterface

// File: rtl/logcap_trigger_sequencer.sv
// logcap_trigger_sequencer: multi-stage pattern/edge/occurrence trigger feeding the capture FSM
module logcap_trigger_sequencer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int NUM_STAGES   = 4,
    parameter int COUNT_WIDTH  = 16,
    parameter int STAGE_W      = 4
) (
    input logic clk,
    input logic reset,
    logcap_trigger_sequencer_if.slave bus
);
    localparam int DEPTH = 2 ** STAGE_W;
    localparam logic [STAGE_W:0] NS = (STAGE_W + 1)'(NUM_STAGES);
    localparam logic [STAGE_W-1:0] LAST_MAX = STAGE_W'(NUM_STAGES - 1);
    localparam logic [8:0] SW = 9'(SAMPLE_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, TRIG} state_t;
    state_t state;

    logic [SAMPLE_WIDTH-1:0] pattern [DEPTH];
    logic [SAMPLE_WIDTH-1:0] care    [DEPTH];
    logic [10:0]             ctrl    [DEPTH];
    logic [COUNT_WIDTH-1:0]  count   [DEPTH];

    logic [STAGE_W-1:0]      last_stage;
    logic [COUNT_WIDTH-1:0]  occ;
    logic [31:0]             sample_idx;
    logic [SAMPLE_WIDTH-1:0] prev_data;
    logic                    prev_valid;

    logic                    wr_ok;
    logic [10:0]             ctl;
    logic [COUNT_WIDTH-1:0]  need_m1;
    logic [SAMPLE_WIDTH-1:0] sel;
    logic                    cur_bit, prev_bit, pattern_hit, edge_hit, hit, done;

    assign wr_ok = bus.cfg_we && state == IDLE && {1'b0, bus.cfg_stage} < NS;

    always_comb begin
        ctl         = ctrl[bus.current_stage];
        need_m1     = count[bus.current_stage] == '0 ? '0 : count[bus.current_stage] - COUNT_WIDTH'(1);
        sel         = SAMPLE_WIDTH'(1) << ctl[7:0];
        cur_bit     = |(bus.sample_data & sel);
        prev_bit    = |(prev_data & sel);
        pattern_hit = ((bus.sample_data ^ pattern[bus.current_stage]) & care[bus.current_stage]) == '0;
        edge_hit    = prev_valid && ({1'b0, ctl[7:0]} < SW) && (ctl[8] ? cur_bit && !prev_bit : prev_bit && !cur_bit);
        hit         = (!ctl[10] || pattern_hit) && (!ctl[9] || edge_hit);
        done        = hit && occ >= need_m1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pattern[i] <= '0;
                care[i]    <= '0;
                ctrl[i]    <= '0;
                count[i]   <= '0;
            end
            bus.cfg_err <= 1'b0;
        end else begin
            bus.cfg_err <= bus.cfg_we && !wr_ok;
            if (wr_ok) begin
                case (bus.cfg_field)
                    2'd0:    pattern[bus.cfg_stage] <= bus.cfg_data;
                    2'd1:    care[bus.cfg_stage]    <= bus.cfg_data;
                    2'd2:    ctrl[bus.cfg_stage]    <= bus.cfg_data[10:0];
                    default: count[bus.cfg_stage]   <= bus.cfg_data[COUNT_WIDTH-1:0];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            bus.idle          <= 1'b1;
            bus.running       <= 1'b0;
            bus.triggered     <= 1'b0;
            bus.trig_pulse    <= 1'b0;
            bus.current_stage <= '0;
            bus.trigger_index <= '0;
            last_stage        <= '0;
            occ               <= '0;
            sample_idx        <= '0;
            prev_data         <= '0;
            prev_valid        <= 1'b0;
        end else begin
            bus.trig_pulse <= 1'b0;
            if (bus.abort) begin
                state         <= IDLE;
                bus.idle      <= 1'b1;
                bus.running   <= 1'b0;
                bus.triggered <= 1'b0;
            end else if (bus.arm && state != RUN) begin
                state             <= RUN;
                bus.idle          <= 1'b0;
                bus.running       <= 1'b1;
                bus.triggered     <= 1'b0;
                bus.current_stage <= '0;
                occ               <= '0;
                sample_idx        <= '0;
                prev_valid        <= 1'b0;
                last_stage        <= {1'b0, bus.cfg_last_stage} < NS ? bus.cfg_last_stage : LAST_MAX;
            end else if (state == RUN && bus.sample_valid) begin
                prev_data  <= bus.sample_data;
                prev_valid <= 1'b1;
                sample_idx <= &sample_idx ? sample_idx : sample_idx + 32'd1;
                if (done && bus.current_stage == last_stage) begin
                    state             <= TRIG;
                    bus.running       <= 1'b0;
                    bus.triggered     <= 1'b1;
                    bus.trig_pulse    <= 1'b1;
                    bus.trigger_index <= sample_idx;
                end else if (done) begin
                    bus.current_stage <= bus.current_stage + STAGE_W'(1);
                    occ               <= '0;
                end else if (hit) begin
                    occ <= occ + COUNT_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_logcap_trigger_sequencer.sv
// tb_logcap_trigger_sequencer: vector table, corner sequences and randomized runs against a sequence-level model
module tb_logcap_trigger_sequencer;
    localparam int SW = 16, NS = 4, CW = 16, STW = 4, NSMP = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0, failures = 0;

    logcap_trigger_sequencer_if #(.SAMPLE_WIDTH(SW), .STAGE_W(STW)) bus ();
    logcap_trigger_sequencer #(.SAMPLE_WIDTH(SW), .NUM_STAGES(NS), .COUNT_WIDTH(CW), .STAGE_W(STW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  stg;
        logic [1:0]  fld;
        logic [15:0] data;
        logic [3:0]  last;
        logic        arm, abt, sv;
        logic [15:0] sd;
        logic [4:0]  flags;
        logic [3:0]  cur;
        logic [31:0] tidx;
    } vec_t;
    vec_t tbl[$];

    logic [15:0] rpat [NS];
    logic [15:0] rcare[NS];
    logic [10:0] rctl [NS];
    int          rcnt [NS];
    logic [15:0] smp  [NSMP];

    function automatic vec_t mk(int we, int stg, int fld, int data, int last, int arm, int abt, int sv, int sd,
                                int fl, int cur, int tidx);
        vec_t v;
        v.we = 1'(we); v.stg = 4'(stg); v.fld = 2'(fld); v.data = 16'(data); v.last = 4'(last);
        v.arm = 1'(arm); v.abt = 1'(abt); v.sv = 1'(sv); v.sd = 16'(sd);
        v.flags = 5'(fl); v.cur = 4'(cur); v.tidx = 32'(tidx);
        return v;
    endfunction

    function automatic logic [31:0] flags();
        return {27'd0, bus.idle, bus.running, bus.triggered, bus.trig_pulse, bus.cfg_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.cfg_we = 1'b0; bus.cfg_stage = '0; bus.cfg_field = '0; bus.cfg_data = '0; bus.cfg_last_stage = '0;
        bus.arm = 1'b0; bus.abort = 1'b0; bus.sample_valid = 1'b0; bus.sample_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int s, input int f, input int d);
        bus.cfg_we = 1'b1; bus.cfg_stage = 4'(s); bus.cfg_field = 2'(f); bus.cfg_data = 16'(d);
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic pulse_in(input bit arm_b, input bit abort_b, input int last);
        bus.arm = arm_b; bus.abort = abort_b; bus.cfg_last_stage = 4'(last);
        tick();
        bus.arm = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic feed(input int d);
        bus.sample_valid = 1'b1; bus.sample_data = 16'(d);
        tick();
        bus.sample_valid = 1'b0;
    endtask

    // Scans the valid-sample list stage by stage; returns the triggering sample index or -1
    function automatic int model(input int last, output int reached);
        int s, occ, ch, need;
        bit cb, pb, ph, eh;
        s = 0; occ = 0;
        for (int i = 0; i < NSMP; i++) begin
            ch = int'(rctl[s][7:0]);
            cb = ch < SW && ((smp[i] >> ch) & 16'h1) != 0;
            pb = i > 0 && ch < SW && ((smp[i-1] >> ch) & 16'h1) != 0;
            ph = ((smp[i] ^ rpat[s]) & rcare[s]) == 16'h0;
            eh = i > 0 && ch < SW && (rctl[s][8] ? (cb && !pb) : (pb && !cb));
            if ((!rctl[s][10] || ph) && (!rctl[s][9] || eh)) begin
                occ++;
                need = rcnt[s] == 0 ? 1 : rcnt[s];
                if (occ >= need) begin
                    if (s == last) begin
                        reached = s;
                        return i;
                    end
                    s++;
                    occ = 0;
                end
            end
        end
        reached = s;
        return -1;
    endfunction

    initial begin
        int exp_idx, reached, lastc, pulses, fed, i;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", flags(), 32'b10000);
        chk("rst_stage", 32'(bus.current_stage), 0);
        chk("rst_tidx", bus.trigger_index, 0);
        reset = 1'b0;

        tbl.push_back(mk(0, 0, 0, 0,      0, 1, 0, 0, 0,      'b01000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 1, 'h1234, 'b00110, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 0,      'b00100, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 1, 0, 0,      'b10000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 'h00A5, 0, 0, 0, 0, 0,      'b10000, 0, 0));
        tbl.push_back(mk(1, 0, 1, 'h00FF, 0, 0, 0, 0, 0,      'b10000, 0, 0));
        tbl.push_back(mk(1, 0, 2, 'h0400, 0, 0, 0, 0, 0,      'b10000, 0, 0));
        tbl.push_back(mk(1, 0, 3, 3,      0, 0, 0, 0, 0,      'b10000, 0, 0));
        tbl.push_back(mk(1, 1, 2, 'h0304, 0, 0, 0, 0, 0,      'b10000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 1, 0, 0, 0,      'b01000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 'h00A5, 'b01000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0, 0, 'h00A5, 'b01000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 'h1234, 'b01000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 'h12A5, 'b01000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0, 0, 'h00A5, 'b01000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 'h00A5, 'b01000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 'h0000, 'b01000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 'h0010, 'b00110, 1, 5));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0, 0, 0,      'b00100, 1, 5));
        tbl.push_back(mk(0, 0, 0, 0,      1, 1, 0, 0, 0,      'b01000, 0, 5));
        tbl.push_back(mk(1, 0, 0, 'hFFFF, 1, 0, 0, 0, 0,      'b01001, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 1, 0, 0,      'b10000, 0, 5));
        tbl.push_back(mk(1, 4, 0, 'h00FF, 0, 0, 0, 0, 0,      'b10001, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 0,      'b10000, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0,      0, 1, 0, 0, 0,      'b01000, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 1, 'h00A5, 'b01000, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 1, 'h00A5, 'b01000, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 1, 'h03A5, 'b00110, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 0,      'b00100, 0, 2));

        foreach (tbl[k]) begin
            bus.cfg_we = tbl[k].we; bus.cfg_stage = tbl[k].stg; bus.cfg_field = tbl[k].fld;
            bus.cfg_data = tbl[k].data; bus.cfg_last_stage = tbl[k].last; bus.arm = tbl[k].arm;
            bus.abort = tbl[k].abt; bus.sample_valid = tbl[k].sv; bus.sample_data = tbl[k].sd;
            tick();
            chk($sformatf("vec%0d_flags", k), flags(), {27'd0, tbl[k].flags});
            chk($sformatf("vec%0d_stage", k), 32'(bus.current_stage), 32'(tbl[k].cur));
            chk($sformatf("vec%0d_tidx", k), bus.trigger_index, tbl[k].tidx);
        end
        idle_in();

        // Abort coinciding with the completing match wins
        pulse_in(0, 1, 0);
        pulse_in(1, 0, 0);
        feed('h00A5);
        feed('h00A5);
        bus.abort = 1'b1;
        feed('h00A5);
        bus.abort = 1'b0;
        chk("abort_flags", flags(), 32'b10000);
        chk("abort_tidx", bus.trigger_index, 2);
        tick();
        chk("abort_nopulse", flags(), 32'b10000);

        // Asynchronous reset while at stage 2
        cfg(0, 2, 0);
        cfg(0, 3, 1);
        cfg(1, 2, 0);
        pulse_in(1, 0, 3);
        feed('h1111);
        feed('h2222);
        chk("pre_rst_stage", 32'(bus.current_stage), 2);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_flags", flags(), 32'b10000);
        chk("async_rst_stage", 32'(bus.current_stage), 0);
        chk("async_rst_tidx", bus.trigger_index, 0);
        @(negedge clk) reset = 1'b0;

        // Last stage clamp and re-arm from triggered
        pulse_in(1, 0, 15);
        chk("clamp_arm", flags(), 32'b01000);
        for (int j = 0; j < 3; j++) feed($urandom);
        chk("clamp_stage3", 32'(bus.current_stage), 3);
        chk("clamp_notrig", flags(), 32'b01000);
        feed($urandom);
        chk("clamp_trig", flags(), 32'b00110);
        chk("clamp_tidx", bus.trigger_index, 3);
        pulse_in(1, 0, 0);
        chk("rearm_flags", flags(), 32'b01000);
        chk("rearm_stage", 32'(bus.current_stage), 0);
        pulse_in(0, 1, 0);

        for (int it = 0; it < 25; it++) begin
            for (int s = 0; s < NS; s++) begin
                rpat[s]  = 16'($urandom);
                rcare[s] = 16'($urandom_range(0, 15));
                rctl[s]  = {1'($urandom), 1'($urandom), 1'($urandom),
                            8'($urandom_range(0, 7) == 0 ? $urandom_range(16, 255) : $urandom_range(0, 3))};
                rcnt[s]  = $urandom_range(0, 3);
                cfg(s, 0, int'(rpat[s]));
                cfg(s, 1, int'(rcare[s]));
                cfg(s, 2, int'(rctl[s]));
                cfg(s, 3, rcnt[s]);
            end
            for (int k = 0; k < NSMP; k++) smp[k] = 16'($urandom);
            lastc = $urandom_range(0, 15);
            exp_idx = model(lastc >= NS ? NS - 1 : lastc, reached);
            pulse_in(1, 0, lastc);
            i = 0; pulses = 0;
            for (int c = 0; c < 200 && i < NSMP; c++) begin
                fed = -1;
                if ($urandom_range(0, 2) != 0) begin
                    bus.sample_valid = 1'b1; bus.sample_data = smp[i]; fed = i; i++;
                end
                tick();
                bus.sample_valid = 1'b0;
                if (bus.trig_pulse) begin
                    pulses++;
                    chk($sformatf("rnd%0d_pulse_at", it), 32'(fed), 32'(exp_idx));
                end
            end
            chk($sformatf("rnd%0d_pulses", it), 32'(pulses), exp_idx >= 0 ? 1 : 0);
            chk($sformatf("rnd%0d_triggered", it), 32'(bus.triggered), exp_idx >= 0 ? 1 : 0);
            if (exp_idx >= 0) chk($sformatf("rnd%0d_tidx", it), bus.trigger_index, 32'(exp_idx));
            else chk($sformatf("rnd%0d_stage", it), 32'(bus.current_stage), 32'(reached));
            pulse_in(0, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
